// File: rtl/light_dance_pkg.sv
// light_dance_pkg: shared run-mode, bounce-direction and PWM width definitions
package light_dance_pkg;
  typedef enum logic [1:0] {SHIFT = 2'b00, ROTL = 2'b01, ROTR = 2'b10, BOUNCE = 2'b11} mode_t;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;
  localparam int PWM_W = 4;
endpackage

// File: rtl/ld_tick_gen.sv
// ld_tick_gen: step prescaler, ticks once every div+1 enabled cycles
module ld_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  // >= lets a lowered div take effect on the next edge instead of wrapping
  always_comb begin
    tick  = en && !clr && (cnt_q >= div);
    cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  // count register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/light_dance_seq.sv
// light_dance_seq: lamp pattern sequencer (shift/rotate/bounce); LIGHT_DANCE_PWM_EN adds duty dimming
module light_dance_seq import light_dance_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             enable,
`ifdef LIGHT_DANCE_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic [WIDTH-1:0] qdata,
  output logic             step_pulse
);
  logic [WIDTH-1:0] pat_q, pat_d, rotl, rotr;
  dir_t             dir_q, dir_d;
  logic             sp_q, sp_d, tick, turn;

  ld_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .arst_n(arst_n), .clr(load), .en(enable), .div(div), .tick(tick)
  );

  // next pattern and bounce direction; load beats any due step
  always_comb begin
    rotl  = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
    rotr  = {pat_q[0], pat_q[WIDTH-1:1]};
    turn  = (dir_q == LEFT) ? pat_q[WIDTH-1] : pat_q[0];
    pat_d = pat_q;
    dir_d = dir_q;
    sp_d  = tick;
    if (load) begin
      pat_d = pdata;
      dir_d = LEFT;
    end else if (tick) begin
      case (mode_t'(mode))
        SHIFT:  pat_d = {din, pat_q[WIDTH-1:1]};
        ROTL:   pat_d = rotl;
        ROTR:   pat_d = rotr;
        BOUNCE: begin
          dir_d = turn ? dir_t'(~dir_q) : dir_q;
          pat_d = ((dir_q == RIGHT) ^ turn) ? rotr : rotl;
        end
        default: pat_d = pat_q;
      endcase
    end
  end

  // pattern, direction and strobe registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      pat_q <= '0;
      dir_q <= LEFT;
      sp_q  <= 1'b0;
    end else begin
      pat_q <= pat_d;
      dir_q <= dir_d;
      sp_q  <= sp_d;
    end
  end

  assign step_pulse = sp_q;

`ifdef LIGHT_DANCE_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
  // free-running PWM phase counter
  always_comb pwm_d = pwm_q + 1'b1;
  // PWM register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) pwm_q <= '0;
    else pwm_q <= pwm_d;
  end
  assign qdata = pat_q & {WIDTH{pwm_q < duty}};
`else
  assign qdata = pat_q;
`endif
endmodule

// File: tb/tb_light_dance_seq.sv
// tb_light_dance_seq: directed plus random checks of light_dance_seq against an arithmetic model
module tb_light_dance_seq;
  logic        clk = 0, arst_n = 0, load = 0, din = 0, enable = 0;
  logic [7:0]  pdata = 0;
  logic [1:0]  mode = 0;
  logic [15:0] div = 0;
  logic [7:0]  qdata;
  logic        step_pulse;
`ifdef LIGHT_DANCE_PWM_EN
  logic [3:0]  duty = 4'd15;
  int          m_pwm = 0;
  int          on_cnt = 0;
`endif
  int vectors = 0, miscompares = 0;
  int m_p = 0, m_cnt = 0, m_dir = 0, m_sp = 0;

  always #5 clk = ~clk;

  light_dance_seq #(.WIDTH(8), .DIV_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .load(load), .pdata(pdata), .din(din), .mode(mode),
    .div(div), .enable(enable),
`ifdef LIGHT_DANCE_PWM_EN
    .duty(duty),
`endif
    .qdata(qdata), .step_pulse(step_pulse)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rl(input int p);
    return ((p << 1) | (p >> 7)) & 255;
  endfunction

  function automatic int rr(input int p);
    return ((p >> 1) | (p << 7)) & 255;
  endfunction

  // advance the model by one clock edge using the current inputs, then compare
  task automatic cyc();
    int tk;
    if (!arst_n) begin
      m_p = 0; m_cnt = 0; m_dir = 0; m_sp = 0;
    end else if (load) begin
      m_p = pdata; m_cnt = 0; m_dir = 0; m_sp = 0;
    end else if (!enable) begin
      m_sp = 0;
    end else begin
      tk = (m_cnt >= int'(div)) ? 1 : 0;
      m_sp = tk;
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) begin
        case (mode)
          2'd0: m_p = (m_p >> 1) | (din ? 128 : 0);
          2'd1: m_p = rl(m_p);
          2'd2: m_p = rr(m_p);
          default: begin
            if (m_dir == 0 && (m_p & 128) != 0) begin m_dir = 1; m_p = rr(m_p); end
            else if (m_dir == 0) m_p = rl(m_p);
            else if ((m_p & 1) != 0) begin m_dir = 0; m_p = rl(m_p); end
            else m_p = rr(m_p);
          end
        endcase
      end
    end
`ifdef LIGHT_DANCE_PWM_EN
    m_pwm = arst_n ? (m_pwm + 1) % 16 : 0;
`endif
    @(posedge clk);
    #1;
`ifdef LIGHT_DANCE_PWM_EN
    chk("qdata", int'(qdata), (m_pwm < int'(duty)) ? m_p : 0);
    if (qdata != 0) on_cnt++;
`else
    chk("qdata", int'(qdata), m_p);
`endif
    chk("step_pulse", int'(step_pulse), m_sp);
  endtask

  initial begin
    // reset beats load
    arst_n = 0; load = 1; pdata = 8'hFF; enable = 1;
    repeat (3) cyc();
    chk("reset_q", int'(qdata), 0);
    chk("reset_sp", int'(step_pulse), 0);
    // rotate left every cycle
    arst_n = 1; pdata = 8'h55; mode = 2'd1; div = 0;
    cyc();
    chk("load_55", int'(qdata), 8'h55);
    load = 0;
    cyc(); chk("rotl_1", int'(qdata), 8'hAA); chk("rotl_sp", int'(step_pulse), 1);
    cyc(); chk("rotl_2", int'(qdata), 8'h55);
    // serial shift-in
    load = 1; pdata = 0; cyc(); load = 0;
    mode = 2'd0; din = 1;
    cyc(); chk("shift_1", int'(qdata), 8'h80);
    cyc(); chk("shift_2", int'(qdata), 8'hC0);
    cyc(); chk("shift_3", int'(qdata), 8'hE0);
    din = 0;
    cyc(); chk("shift_4", int'(qdata), 8'h70);
    // bounce up, flip at the top, down, flip at the bottom
    load = 1; pdata = 8'h01; cyc(); load = 0;
    mode = 2'd3;
    repeat (7) cyc();
    chk("bounce_top", int'(qdata), 8'h80);
    cyc(); chk("bounce_flip_r", int'(qdata), 8'h40);
    repeat (6) cyc();
    chk("bounce_bot", int'(qdata), 8'h01);
    cyc(); chk("bounce_flip_l", int'(qdata), 8'h02);
    // divided rotate right, then a lowered div mid-count
    div = 3; mode = 2'd2; load = 1; pdata = 8'h80; cyc(); load = 0;
    repeat (3) cyc();
    chk("div_hold", int'(qdata), 8'h80);
    cyc(); chk("div_step", int'(qdata), 8'h40); chk("div_sp", int'(step_pulse), 1);
    repeat (4) cyc();
    chk("div_step2", int'(qdata), 8'h20);
    repeat (2) cyc();
    div = 1;
    cyc(); chk("div_lower", int'(qdata), 8'h10);
    // load exactly when a tick is due
    div = 3; repeat (3) cyc();
    load = 1; pdata = 8'h3C; cyc(); load = 0;
    chk("load_due_q", int'(qdata), 8'h3C);
    chk("load_due_sp", int'(step_pulse), 0);
    enable = 0;
    repeat (10) cyc();
    chk("frozen_q", int'(qdata), 8'h3C);
    chk("frozen_sp", int'(step_pulse), 0);
    enable = 1;
`ifdef LIGHT_DANCE_PWM_EN
    duty = 4'd8; load = 1; pdata = 8'hFF; mode = 2'd1; cyc(); load = 0;
    on_cnt = 0;
    repeat (16) cyc();
    chk("pwm_duty8", on_cnt, 8);
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      arst_n = ($urandom_range(63) != 0);
      load   = ($urandom_range(15) == 0);
      enable = ($urandom_range(7) != 0);
      pdata  = 8'($urandom);
      din    = 1'($urandom);
      mode   = 2'($urandom);
      div    = 16'($urandom_range(5));
`ifdef LIGHT_DANCE_PWM_EN
      duty   = 4'($urandom);
`endif
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
